// File: rtl/grouper_pkg.sv
// Shared definitions for the grouper word-buffer path.
//   word_writer_state : FSM states of the producer (word_writer)
//   WORD_TERM         : element value that terminates a word / the list;
//                       wide enough to be sliced to any element width.
package grouper_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    TERM_W,
    TERM_L,
    DONE
  } word_writer_state;

  localparam logic [63:0] WORD_TERM = '0;

endpackage

// File: rtl/word_writer.sv
// word_writer: writes a valid/ready byte stream into a single-port SRAM as a
// zero-delimited word list (word bytes, 0x00, ..., final extra 0x00).
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   cs           : start pulse, honoured in IDLE/DONE only
//   in_valid/in_ready, in_data, in_eow, in_eol : byte stream handshake
//   mem_we/mem_addr/mem_din : registered SRAM write port
//   word_count   : words terminated so far
//   overflow     : sticky, list truncated for lack of space
//   bad_byte     : sticky, a 0x00 payload byte was dropped
//   done         : level, list terminator captured; held until next cs
module word_writer
  import grouper_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_eow,
  input  logic                  in_eol,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic [ADDR_WIDTH-1:0] word_count,
  output logic                  overflow,
  output logic                  bad_byte,
  output logic                  done
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  // Last slot a payload byte may take: two slots stay reserved for the
  // word terminator and the list terminator.
  localparam logic [ADDR_WIDTH-1:0] LAST_DATA_ADDR = ADDR_WIDTH'(DEPTH - 3);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR      = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [DATA_WIDTH-1:0] TERM_BYTE      = DATA_WIDTH'(WORD_TERM);

  word_writer_state state, state_nxt;

  logic [ADDR_WIDTH-1:0] addr, addr_nxt;
  logic                  wlen_nz, wlen_nz_nxt;
  logic                  eol_lat, eol_lat_nxt;
  logic [ADDR_WIDTH-1:0] word_count_nxt;
  logic                  overflow_nxt, bad_byte_nxt, done_nxt;
  logic                  mem_we_nxt;
  logic [ADDR_WIDTH-1:0] mem_addr_nxt;
  logic [DATA_WIDTH-1:0] mem_din_nxt;

  assign in_ready = (state == RECV) && (addr <= LAST_DATA_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr       <= '0;
      wlen_nz    <= 1'b0;
      eol_lat    <= 1'b0;
      word_count <= '0;
      overflow   <= 1'b0;
      bad_byte   <= 1'b0;
      done       <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
    end else begin
      state      <= state_nxt;
      addr       <= addr_nxt;
      wlen_nz    <= wlen_nz_nxt;
      eol_lat    <= eol_lat_nxt;
      word_count <= word_count_nxt;
      overflow   <= overflow_nxt;
      bad_byte   <= bad_byte_nxt;
      done       <= done_nxt;
      mem_we     <= mem_we_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_din    <= mem_din_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    addr_nxt       = addr;
    wlen_nz_nxt    = wlen_nz;
    eol_lat_nxt    = eol_lat;
    word_count_nxt = word_count;
    overflow_nxt   = overflow;
    bad_byte_nxt   = bad_byte;
    done_nxt       = done;
    mem_we_nxt     = 1'b0;
    mem_addr_nxt   = mem_addr;
    mem_din_nxt    = mem_din;

    unique case (state)
      IDLE, DONE: begin
        if (cs) begin
          addr_nxt       = '0;
          wlen_nz_nxt    = 1'b0;
          eol_lat_nxt    = 1'b0;
          word_count_nxt = '0;
          overflow_nxt   = 1'b0;
          bad_byte_nxt   = 1'b0;
          done_nxt       = 1'b0;
          state_nxt      = RECV;
        end else if (state == DONE) begin
          // One cycle after the final write is driven, so the SRAM has
          // already captured the list terminator when done is seen.
          done_nxt = 1'b1;
        end
      end

      RECV: begin
        if (in_valid && (addr > LAST_DATA_ADDR)) begin
          // No room: refuse the byte and close the list cleanly.
          overflow_nxt = 1'b1;
          state_nxt    = wlen_nz ? TERM_W : TERM_L;
        end else if (in_valid) begin
          if (in_data != TERM_BYTE) begin
            mem_we_nxt   = 1'b1;
            mem_addr_nxt = addr;
            mem_din_nxt  = in_data;
            addr_nxt     = addr + 1'b1;
            wlen_nz_nxt  = 1'b1;
            if (in_eow || in_eol) begin
              state_nxt   = TERM_W;
              eol_lat_nxt = in_eol;
            end
          end else begin
            // A zero byte would read as a terminator; drop it but keep
            // its word/list flags so the list structure still closes.
            bad_byte_nxt = 1'b1;
            if ((in_eow || in_eol) && wlen_nz) begin
              state_nxt   = TERM_W;
              eol_lat_nxt = in_eol;
            end else if (in_eol) begin
              state_nxt = TERM_L;
            end
          end
        end
      end

      TERM_W: begin
        mem_we_nxt   = 1'b1;
        mem_addr_nxt = addr;
        mem_din_nxt  = TERM_BYTE;
        if (addr != LAST_ADDR) begin
          addr_nxt = addr + 1'b1;
        end
        word_count_nxt = word_count + 1'b1;
        wlen_nz_nxt    = 1'b0;
        state_nxt      = (eol_lat || overflow) ? TERM_L : RECV;
      end

      TERM_L: begin
        mem_we_nxt   = 1'b1;
        mem_addr_nxt = addr;
        mem_din_nxt  = TERM_BYTE;
        state_nxt    = DONE;
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_word_writer.sv
module tb_word_writer;
  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cs = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_eow = 1'b0;
  logic          in_eol = 1'b0;
  logic          in_ready, mem_we, overflow, bad_byte, done;
  logic [AW-1:0] mem_addr, word_count;
  logic [DW-1:0] mem_din;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  word_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs),
    .in_valid(in_valid), .in_data(in_data), .in_eow(in_eow), .in_eol(in_eol),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .word_count(word_count), .overflow(overflow), .bad_byte(bad_byte), .done(done)
  );

  // External single-port SRAM
  logic [DW-1:0] sram [DEPTH];
  always @(posedge clk) if (mem_we) sram[mem_addr] <= mem_din;

  // Token list presented to the DUT
  logic [DW-1:0] tk_d   [64];
  logic          tk_eow [64];
  logic          tk_eol [64];

  // Reference model results
  int            m_wc, m_nacc, m_len;
  bit            m_ovf, m_bad;
  logic [DW-1:0] m_img [DEPTH];
  int            wq_addr [$];
  int            wq_data [$];

  bit rdy_log [$];
  int last_cyc;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic emit(input int pos, input int d);
    wq_addr.push_back(pos);
    wq_data.push_back(d);
    m_img[pos] = DW'(d);
  endtask

  // List-level reference: payload bytes laid out back to back, each
  // non-empty word followed by one 0x00, list closed by one more 0x00.
  // A byte only fits while two slots remain for the terminators.
  task automatic model(input int n);
    int pos;
    int wlen;
    pos = 0; wlen = 0;
    m_wc = 0; m_ovf = 0; m_bad = 0; m_nacc = 0;
    wq_addr.delete(); wq_data.delete();
    for (int i = 0; i < n; i++) begin
      if (pos > int'(DEPTH) - 3) begin
        m_ovf = 1;
        break;
      end
      m_nacc++;
      if (tk_d[i] != 0) begin
        emit(pos, int'(tk_d[i])); pos++; wlen++;
      end else begin
        m_bad = 1;
      end
      if ((tk_eow[i] || tk_eol[i]) && wlen > 0) begin
        emit(pos, 0); pos++; m_wc++; wlen = 0;
      end
      if (tk_eol[i]) break;
    end
    if (m_ovf && wlen > 0) begin
      emit(pos, 0); pos++; m_wc++;
    end
    emit(pos, 0);
    m_len = pos + 1;
  endtask

  task automatic set_tok(input int k, input int d, input bit eow, input bit eol);
    tk_d[k] = DW'(d); tk_eow[k] = eow; tk_eol[k] = eol;
  endtask

  // Every driven write must be the next one the model predicts.
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      int ea, ed;
      checks++;
      if (wq_addr.size() == 0) begin
        errors++;
        $display("FAIL write_seq: unexpected write addr=%0d din=0x%0h", mem_addr, mem_din);
      end else begin
        ea = wq_addr.pop_front();
        ed = wq_data.pop_front();
        if (int'(mem_addr) != ea || int'(mem_din) != ed) begin
          errors++;
          $display("FAIL write_seq: got addr=%0d din=0x%0h, expected addr=%0d din=0x%0h",
                   mem_addr, mem_din, ea, ed);
        end
      end
    end
  end

  task automatic run_list(input int n, input bit gaps, input bit cs_mid);
    int  i, cyc;
    bit  v, fire;
    model(n);
    @(negedge clk); cs = 1'b1;
    @(negedge clk); cs = 1'b0;
    check("start_done",     int'(done), 0);
    check("start_wc",       int'(word_count), 0);
    check("start_overflow", int'(overflow), 0);
    check("start_bad",      int'(bad_byte), 0);
    i = 0; cyc = 0;
    rdy_log.delete();
    while (1) begin
      if (done) break;
      if (cyc == 300) begin
        check("done_timeout", 0, 1);
        rst_n = 1'b0; #1; rst_n = 1'b1;
        wq_addr.delete(); wq_data.delete();
        break;
      end
      v = (i < n) && (!gaps || $urandom_range(0, 3) != 0);
      in_valid = v;
      in_data  = v ? tk_d[i] : '0;
      in_eow   = v ? tk_eow[i] : 1'b0;
      in_eol   = v ? tk_eol[i] : 1'b0;
      cs       = cs_mid && (cyc == 1);
      rdy_log.push_back(in_ready);
      fire = v && in_ready;
      @(posedge clk);
      if (fire) i++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0; in_eow = 1'b0; in_eol = 1'b0; cs = 1'b0;
    last_cyc = cyc;
    check("consumed",    i, m_nacc);
    check("word_count",  int'(word_count), m_wc);
    check("overflow",    int'(overflow), int'(m_ovf));
    check("bad_byte",    int'(bad_byte), int'(m_bad));
    check("writes_left", wq_addr.size(), 0);
    for (int a = 0; a < m_len; a++)
      check($sformatf("sram[%0d]", a), int'(sram[a]), int'(m_img[a]));
  endtask

  task automatic check_ab_c_timing;
    int r;
    r = 0;
    foreach (rdy_log[k]) r = (r << 1) | int'(rdy_log[k]);
    check("ready_len",     rdy_log.size(), 7);
    check("ready_pattern", r, 7'b1101000);
    check("done_latency",  last_cyc, 7);
  endtask

  task automatic load_ab_c;
    set_tok(0, 8'h41, 0, 0);
    set_tok(1, 8'h42, 1, 0);
    set_tok(2, 8'h43, 1, 1);
  endtask

  initial begin
    int n;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready",   int'(in_ready), 0);
    check("rst_mem_we",     int'(mem_we), 0);
    check("rst_mem_addr",   int'(mem_addr), 0);
    check("rst_mem_din",    int'(mem_din), 0);
    check("rst_word_count", int'(word_count), 0);
    check("rst_overflow",   int'(overflow), 0);
    check("rst_bad_byte",   int'(bad_byte), 0);
    check("rst_done",       int'(done), 0);
    rst_n = 1'b1;

    // "AB" "C" eol, in_valid held high
    load_ab_c();
    model(3);
    check("pin1_len", m_len, 6);
    check("pin1_wc",  m_wc, 2);
    check("pin1_img", {24'h0, m_img[0], m_img[1], m_img[2]}, 32'h414200);
    check("pin1_tail",{8'h0, m_img[3], m_img[4], m_img[5]}, 32'h430000);
    run_list(3, 0, 0);
    check_ab_c_timing();

    // 16 plain bytes, no word end: overflow truncation
    for (int k = 0; k < 16; k++) set_tok(k, k + 1, 0, 0);
    model(16);
    check("pin2_nacc", m_nacc, 14);
    check("pin2_ovf",  int'(m_ovf), 1);
    check("pin2_wc",   m_wc, 1);
    check("pin2_len",  m_len, 16);
    check("pin2_b13",  int'(m_img[13]), 8'h0E);
    run_list(16, 0, 0);

    // Word ending at slot 13, then the next byte overflows
    for (int k = 0; k < 12; k++) set_tok(k, k + 1, k == 11, 0);
    set_tok(12, 8'h41, 1, 0);
    set_tok(13, 8'h42, 1, 1);
    model(14);
    check("pin3_nacc", m_nacc, 13);
    check("pin3_ovf",  int'(m_ovf), 1);
    check("pin3_wc",   m_wc, 2);
    check("pin3_tail", {8'h0, m_img[13], m_img[14], m_img[15]}, 32'h410000);
    run_list(14, 0, 0);

    // Zero payload byte dropped
    set_tok(0, 8'h41, 0, 0);
    set_tok(1, 8'h00, 0, 0);
    set_tok(2, 8'h42, 1, 1);
    model(3);
    check("pin4_img", {m_img[0], m_img[1], m_img[2], m_img[3]}, 32'h41420000);
    check("pin4_bad", int'(m_bad), 1);
    run_list(3, 0, 0);

    // Lone zero with eol
    set_tok(0, 8'h00, 1, 1);
    model(1);
    check("pin5_len", m_len, 1);
    check("pin5_wc",  m_wc, 0);
    run_list(1, 1, 0);

    // Asynchronous reset mid-list after three bytes
    wq_addr.delete(); wq_data.delete();
    for (int k = 0; k < 3; k++) begin
      wq_addr.push_back(k);
      wq_data.push_back(8'h11 * (k + 1));
    end
    @(negedge clk); cs = 1'b1;
    @(negedge clk); cs = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = DW'(8'h11 * (k + 1));
      check("mid_ready", int'(in_ready), 1);
      @(posedge clk);
      @(negedge clk);
    end
    #1 rst_n = 1'b0;
    #1;
    check("arst_in_ready",   int'(in_ready), 0);
    check("arst_mem_we",     int'(mem_we), 0);
    check("arst_mem_addr",   int'(mem_addr), 0);
    check("arst_mem_din",    int'(mem_din), 0);
    check("arst_word_count", int'(word_count), 0);
    check("arst_overflow",   int'(overflow), 0);
    check("arst_bad_byte",   int'(bad_byte), 0);
    check("arst_done",       int'(done), 0);
    in_valid = 1'b0; in_data = '0;
    #1 rst_n = 1'b1;

    // Restart from address 0, with a cs pulse in RECV that must be ignored
    load_ab_c();
    run_list(3, 0, 1);
    check_ab_c_timing();

    // Randomized lists, each restarted by cs from DONE
    for (int r = 0; r < 40; r++) begin
      n = $urandom_range(1, 20);
      for (int k = 0; k < n; k++) begin
        tk_d[k]   = ($urandom_range(0, 5) == 0) ? '0 : DW'($urandom_range(1, 255));
        tk_eow[k] = ($urandom_range(0, 2) == 0);
        tk_eol[k] = (k == n - 1);
        if (tk_eol[k]) tk_eow[k] = 1'b1;
      end
      run_list(n, 1, 0);
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
